decode_issue_scoreboard: RTL and testbench
==========================================

# decode_issue_scoreboard

Issue controller for the decode stage of the in-order RISC-V pipeline. Takes the opcode and register fields produced by the instruction field decoder and holds one pending-write bit per architectural register. It decides each cycle whether the instruction in ID may issue to EX, or must stall for a RAW/WAW hazard or a serialising FENCE/SYSTEM drain. Writeback-stage completions clear pending bits. Branch flushes squash only the instruction held in ID.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  7  instruction[6:0]
- id_rd  in  5  instruction[11:7]
- id_rs1  in  5  instruction[19:15]
- id_rs2  in  5  instruction[24:20]
- ex_ready  in  1  EX can accept an instruction this cycle
- flush  in  1  branch/jump redirect; squashes the ID instruction this cycle
- wb_valid  in  1  a register write retires this cycle
- wb_rd  in  5  destination of the retiring write
- issue_valid  out  1  ID instruction issues this cycle (combinational)
- id_stall  out  1  ID must hold its instruction (combinational)
- busy_mask  out  32  registered pending-write bits; bit 0 always 0
- drain_active  out  1  state is DRAIN
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with id_stall=1
- wb_unexpected  out  1  sticky; a writeback hit a non-pending register

## Operation
- Operand use by opcode:
  - 0110011 uses rs1, rs2 and rd.
  - 0010011, 0000011 and 1100111 use rs1 and rd.
  - 0100011 and 1100011 use rs1 and rs2.
  - 0110111, 0010111 and 1101111 use rd only.
  - 0001111 and 1110011 are serialising.
  - Any other opcode uses nothing and issues freely.
  - x0 as a source never creates a hazard. x0 as a destination never sets a pending bit.
- Effective pending: eff = busy_mask & ~onehot(wb_rd when wb_valid). Writeback bypasses same-cycle.
- Hazard conditions:
  - raw: a used rs has its eff bit set.
  - waw: the used rd (non-zero) has its eff bit set.
- State machine, 2 states: RUN, DRAIN.
  - RUN: hazard = id_valid & (raw | waw).
  - RUN: a serialising opcode with id_valid, no flush, and eff != 0 moves to DRAIN.
  - RUN: a serialising opcode with eff == 0 issues directly.
  - DRAIN: id_stall=1 while eff != 0. Returns to RUN when eff == 0, and issues that same cycle if ex_ready.
  - DRAIN: flush returns to RUN immediately.
- Output equations:
  - id_stall = id_valid & ~flush & (hazard | DRAIN-not-empty | serialise-not-empty).
  - issue_valid = id_valid & ~flush & ~id_stall & ex_ready.
  - ex_ready=0 alone does not assert id_stall; the instruction simply waits.
- On issue_valid with rd used and rd≠0, set busy_mask[rd] next cycle.
- On wb_valid, clear busy_mask[wb_rd] next cycle. If set and clear hit the same register in one cycle, set wins.
- wb_valid with busy_mask[wb_rd]=0 and wb_rd≠0 sets wb_unexpected. No other effect.
- stall_cycles increments on every id_stall=1 cycle and saturates at all-ones.

## Timing
- Reset values:
  - busy_mask = 0
  - state = RUN (drain_active = 0)
  - stall_cycles = 0
  - wb_unexpected = 0
  - issue_valid and id_stall follow the inputs combinationally. With busy_mask=0 they are hazard-free.
- rst dominates all same-cycle events. An in-flight reset discards all pending bits.
- Latency:
  - Issue to pending bit visible: 1 cycle.
  - Writeback to hazard release: 0 cycles (bypass).
  - DRAIN exit: in the cycle the last pending write retires.
- Flush has priority over issue and over hazards. The squashed instruction sets no bit. Pending bits of already-issued instructions remain.
- Simultaneous flush and wb_valid: the clear still applies.
- No combinational path from ex_ready to id_stall.

## Test plan
- Back-to-back issue:
  - Stimulus: issue add x5,x1,x2 (0110011), then sub x6,x5,x3 next cycle, no wb.
  - Required: second cycle id_stall=1, busy_mask=0x20, stall_cycles increments.
  - Required: wb_valid, wb_rd=5 → same-cycle issue_valid=1, busy_mask=0x40 next cycle.
- x0 handling:
  - Stimulus: issue addi x0,x0,1, then add x7,x0,x0.
  - Required: busy_mask stays 0, no stall, both issue.
- WAW and set-wins:
  - Stimulus: busy_mask[8]=1, lw x8 in ID, wb_rd=8 same cycle.
  - Required: lw issues and busy_mask[8] remains 1 next cycle.
- FENCE drain:
  - Stimulus: busy_mask=0x0C, FENCE (0001111) in ID.
  - Required: drain_active=1, id_stall=1.
  - Required: after wb x2 the state holds DRAIN. After wb x3, FENCE issues that cycle and drain_active=0 next cycle.
- Flush:
  - Stimulus: a hazarded add in ID with flush=1.
  - Required: id_stall=0, issue_valid=0, busy_mask unchanged.
  - Stimulus: flush during DRAIN.
  - Required: RUN next cycle.
- Reset and counters:
  - Stimulus: rst mid-DRAIN with busy_mask=0xFFFE.
  - Required: all registered outputs are zero next cycle.
  - Stimulus: wb_rd=4 with bit 4 clear.
  - Required: wb_unexpected=1, held until reset.
  - Stimulus: force 70000 stall cycles.
  - Required: stall_cycles = 0xFFFF.

Source files
------------

// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard
//
// Issue controller for the ID stage of the in-order RISC-V pipeline. Keeps one
// pending-write bit per architectural register. Each cycle it decides whether
// the instruction in ID issues to EX, or stalls for one of these reasons:
//   - a RAW or WAW hazard;
//   - a FENCE/SYSTEM instruction waiting for outstanding writes to drain.
// Writebacks clear pending bits, with a same-cycle bypass. A flush squashes
// only the instruction held in ID.
//
// Handshake: the ID instruction transfers to EX in a cycle where id_valid=1,
// flush=0, id_stall=0 and ex_ready=1; issue_valid marks that cycle. id_stall
// never depends on ex_ready, so ID simply holds while EX is not ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid          ID holds a valid instruction
//   id_opcode         instruction[6:0]
//   id_rd             instruction[11:7]
//   id_rs1            instruction[19:15]
//   id_rs2            instruction[24:20]
//   ex_ready          EX can accept an instruction this cycle
//   flush             squash the ID instruction this cycle
//   wb_valid, wb_rd   a register write retires this cycle
//   issue_valid       ID instruction issues this cycle (combinational)
//   id_stall          ID must hold its instruction (combinational)
//   busy_mask         registered pending-write bits, bit 0 always 0
//   drain_active      FSM is in DRAIN (state debug view)
//   stall_cycles      saturating count of id_stall cycles
//   wb_unexpected     sticky: a writeback hit a non-pending register
module decode_issue_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [6:0]             id_opcode,
    input  logic [4:0]             id_rd,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   ex_ready,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    output logic                   issue_valid,
    output logic                   id_stall,
    output logic [31:0]            busy_mask,
    output logic                   drain_active,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   wb_unexpected
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;

    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        serial;
    logic [31:0] wb_onehot;
    logic [31:0] set_onehot;
    logic [31:0] eff;
    logic        eff_any;
    logic        raw;
    logic        waw;
    logic        hazard;
    logic        drain_ne;
    logic        serial_ne;

    // Operand usage by major opcode.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        serial  = 1'b0;
        case (id_opcode)
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                use_rd = 1'b1;
            end
            7'b0001111, 7'b1110011: begin
                serial = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A retiring write is already considered complete this cycle (bypass).
    assign wb_onehot = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign eff       = busy_mask & ~wb_onehot;
    assign eff_any   = |eff;

    // x0 is never pending, but the explicit checks keep the intent obvious.
    assign raw = (use_rs1 && (id_rs1 != 5'd0) && eff[id_rs1])
               | (use_rs2 && (id_rs2 != 5'd0) && eff[id_rs2]);
    assign waw = use_rd && (id_rd != 5'd0) && eff[id_rd];

    assign hazard    = id_valid & (raw | waw);
    assign drain_ne  = (state == DRAIN) & eff_any;
    assign serial_ne = (state == RUN) & serial & eff_any;

    assign id_stall    = id_valid & ~flush & (hazard | drain_ne | serial_ne);
    assign issue_valid = id_valid & ~flush & ~id_stall & ex_ready;

    assign set_onehot = (issue_valid && use_rd && (id_rd != 5'd0))
                      ? (32'd1 << id_rd) : 32'd0;

    assign drain_active = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            busy_mask     <= 32'd0;
            stall_cycles  <= '0;
            wb_unexpected <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (id_valid && !flush && serial && eff_any)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // The last retiring write releases the drain in its own cycle.
                    if (flush || !eff_any)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase

            // Set after clear, so a same-register issue wins over a retire.
            busy_mask <= ((busy_mask & ~wb_onehot) | set_onehot) & 32'hFFFF_FFFE;

            if (id_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;

            if (wb_valid && (wb_rd != 5'd0) && !busy_mask[wb_rd])
                wb_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Directed bench for decode_issue_scoreboard. Inputs change 1 time unit after
// the rising edge. Combinational outputs are checked after the inputs settle,
// and registered outputs are checked 1 unit after the following edge.
module tb_decode_issue_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        ex_ready;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        issue_valid;
    logic        id_stall;
    logic [31:0] busy_mask;
    logic        drain_active;
    logic [15:0] stall_cycles;
    logic        wb_unexpected;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    decode_issue_scoreboard #(.STALL_CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rd        (id_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_ready     (ex_ready),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .issue_valid  (issue_valid),
        .id_stall     (id_stall),
        .busy_mask    (busy_mask),
        .drain_active (drain_active),
        .stall_cycles (stall_cycles),
        .wb_unexpected(wb_unexpected)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking task.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_opcode = 7'd0;
        id_rd     = 5'd0;
        id_rs1    = 5'd0;
        id_rs2    = 5'd0;
        ex_ready  = 1'b1;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
    endtask

    task automatic drive_id(input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid  = 1'b1;
        id_opcode = op;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
    endtask

    task automatic drive_wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check("rst_busy", busy_mask, 32'h0);
        check("rst_drain", {31'd0, drain_active}, 32'd0);
        check("rst_stallcnt", {16'd0, stall_cycles}, 32'd0);
        check("rst_wbu", {31'd0, wb_unexpected}, 32'd0);

        // Serialising instruction with nothing pending issues directly.
        drive_id(OP_FENCE, 5'd0, 5'd0, 5'd0);
        settle();
        check("fence_free_issue", {31'd0, issue_valid}, 32'd1);
        check("fence_free_stall", {31'd0, id_stall}, 32'd0);
        step();
        idle();
        check("fence_free_drain", {31'd0, drain_active}, 32'd0);

        // ex_ready low: no issue, no stall, nothing marked pending.
        drive_id(OP_R, 5'd9, 5'd1, 5'd2);
        ex_ready = 1'b0;
        settle();
        check("exrdy_issue", {31'd0, issue_valid}, 32'd0);
        check("exrdy_stall", {31'd0, id_stall}, 32'd0);
        step();
        idle();
        check("exrdy_busy", busy_mask, 32'h0);

        // Back-to-back: add x5,x1,x2 then sub x6,x5,x3.
        drive_id(OP_R, 5'd5, 5'd1, 5'd2);
        settle();
        check("add_issue", {31'd0, issue_valid}, 32'd1);
        step();
        check("add_busy", busy_mask, 32'h20);
        drive_id(OP_R, 5'd6, 5'd5, 5'd3);
        settle();
        check("raw_stall", {31'd0, id_stall}, 32'd1);
        check("raw_issue", {31'd0, issue_valid}, 32'd0);
        step();
        check("raw_busy", busy_mask, 32'h20);
        check("raw_stallcnt", {16'd0, stall_cycles}, 32'd1);
        drive_wb(5'd5);
        settle();
        check("bypass_issue", {31'd0, issue_valid}, 32'd1);
        check("bypass_stall", {31'd0, id_stall}, 32'd0);
        step();
        idle();
        check("bypass_busy", busy_mask, 32'h40);
        drive_wb(5'd6);
        step();
        idle();
        check("clear6_busy", busy_mask, 32'h0);

        // x0 handling: addi x0,x0,1 then add x7,x0,x0.
        drive_id(OP_I, 5'd0, 5'd0, 5'd0);
        settle();
        check("x0_addi_issue", {31'd0, issue_valid}, 32'd1);
        step();
        check("x0_busy", busy_mask, 32'h0);
        drive_id(OP_R, 5'd7, 5'd0, 5'd0);
        settle();
        check("x0_add_stall", {31'd0, id_stall}, 32'd0);
        check("x0_add_issue", {31'd0, issue_valid}, 32'd1);
        step();
        idle();
        check("x7_busy", busy_mask, 32'h80);
        drive_wb(5'd7);
        step();
        idle();

        // WAW, then set-wins on the same register.
        drive_id(OP_LOAD, 5'd8, 5'd1, 5'd0);
        step();
        check("lw8_busy", busy_mask, 32'h100);
        settle();
        check("waw_stall", {31'd0, id_stall}, 32'd1);
        step();
        check("waw_stallcnt", {16'd0, stall_cycles}, 32'd2);
        drive_wb(5'd8);
        settle();
        check("setwin_issue", {31'd0, issue_valid}, 32'd1);
        step();
        idle();
        check("setwin_busy", busy_mask, 32'h100);
        drive_wb(5'd8);
        step();
        idle();
        check("clear8_busy", busy_mask, 32'h0);

        // FENCE drain with x2 and x3 pending.
        drive_id(OP_I, 5'd2, 5'd0, 5'd0);
        step();
        drive_id(OP_I, 5'd3, 5'd0, 5'd0);
        step();
        check("fence_pre_busy", busy_mask, 32'h0C);
        drive_id(OP_FENCE, 5'd0, 5'd0, 5'd0);
        settle();
        check("fence_stall", {31'd0, id_stall}, 32'd1);
        check("fence_issue0", {31'd0, issue_valid}, 32'd0);
        step();
        check("fence_drain", {31'd0, drain_active}, 32'd1);
        drive_wb(5'd2);
        settle();
        check("drain_wb2_stall", {31'd0, id_stall}, 32'd1);
        step();
        check("drain_wb2_state", {31'd0, drain_active}, 32'd1);
        check("drain_wb2_busy", busy_mask, 32'h08);
        drive_wb(5'd3);
        settle();
        check("drain_wb3_issue", {31'd0, issue_valid}, 32'd1);
        check("drain_wb3_stall", {31'd0, id_stall}, 32'd0);
        step();
        idle();
        check("drain_exit", {31'd0, drain_active}, 32'd0);
        check("drain_busy", busy_mask, 32'h0);
        check("drain_stallcnt", {16'd0, stall_cycles}, 32'd4);

        // Flush of a hazarded add.
        drive_id(OP_R, 5'd5, 5'd1, 5'd2);
        step();
        drive_id(OP_R, 5'd6, 5'd5, 5'd3);
        flush = 1'b1;
        settle();
        check("flush_stall", {31'd0, id_stall}, 32'd0);
        check("flush_issue", {31'd0, issue_valid}, 32'd0);
        step();
        idle();
        check("flush_busy", busy_mask, 32'h20);
        check("flush_stallcnt", {16'd0, stall_cycles}, 32'd4);

        // Flush during DRAIN.
        drive_id(OP_FENCE, 5'd0, 5'd0, 5'd0);
        step();
        check("fl_drain_in", {31'd0, drain_active}, 32'd1);
        flush = 1'b1;
        settle();
        check("fl_drain_stall", {31'd0, id_stall}, 32'd0);
        step();
        idle();
        check("fl_drain_out", {31'd0, drain_active}, 32'd0);
        check("fl_drain_busy", busy_mask, 32'h20);

        // Flush and writeback together: the clear still applies.
        drive_id(OP_R, 5'd6, 5'd5, 5'd3);
        flush = 1'b1;
        drive_wb(5'd5);
        step();
        idle();
        check("flush_wb_busy", busy_mask, 32'h0);

        // Unexpected writebacks: x0 is ignored, x4 is flagged and sticky.
        drive_wb(5'd0);
        step();
        idle();
        check("wbu_x0", {31'd0, wb_unexpected}, 32'd0);
        drive_wb(5'd4);
        step();
        idle();
        check("wbu_x4", {31'd0, wb_unexpected}, 32'd1);
        check("wbu_x4_busy", busy_mask, 32'h0);
        step();
        step();
        check("wbu_sticky", {31'd0, wb_unexpected}, 32'd1);

        // Reset mid-DRAIN with x1..x15 pending.
        for (int i = 1; i < 16; i++) begin
            drive_id(OP_I, 5'(i), 5'd0, 5'd0);
            step();
        end
        check("fill_busy", busy_mask, 32'hFFFE);
        drive_id(OP_FENCE, 5'd0, 5'd0, 5'd0);
        step();
        check("rst_pre_drain", {31'd0, drain_active}, 32'd1);
        rst = 1'b1;
        drive_wb(5'd1);
        step();
        rst = 1'b0;
        idle();
        check("rst2_busy", busy_mask, 32'h0);
        check("rst2_drain", {31'd0, drain_active}, 32'd0);
        check("rst2_stallcnt", {16'd0, stall_cycles}, 32'd0);
        check("rst2_wbu", {31'd0, wb_unexpected}, 32'd0);

        // Stall counter saturation: hold a RAW hazard for 70000 cycles.
        drive_id(OP_R, 5'd5, 5'd1, 5'd2);
        step();
        drive_id(OP_R, 5'd6, 5'd5, 5'd3);
        for (int i = 0; i < 100; i++) step();
        check("cnt_100", {16'd0, stall_cycles}, 32'd100);
        for (int i = 100; i < 70000; i++) step();
        check("cnt_sat", {16'd0, stall_cycles}, 32'hFFFF);
        check("sat_busy", busy_mask, 32'h20);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
